// File: rtl/framebuffer_write_scheduler_pkg.sv
// Shared types for the framebuffer write scheduler: FSM states and the queued pixel write.
package framebuffer_write_scheduler_pkg;

    // Datapath widths are fixed by the pixel BRAM port.
    localparam int ADDR_BITS  = 18;
    localparam int COLOR_BITS = 16;

    typedef enum logic [1:0] {IDLE, CLEAR, STREAM, DONE} FbState;

    typedef struct packed {
        logic [ADDR_BITS-1:0]  addr;
        logic [COLOR_BITS-1:0] data;
    } PixelWrite;

    function automatic bit is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/framebuffer_write_scheduler_if.sv
// Pixel stream from the raytracing controller into the write scheduler.
interface framebuffer_write_scheduler_if;
    import framebuffer_write_scheduler_pkg::*;

    logic                  pix_valid;
    logic                  pix_ready;
    logic [15:0]           pix_x;
    logic [15:0]           pix_y;
    logic [COLOR_BITS-1:0] pix_data;

    modport master (output pix_valid, pix_x, pix_y, pix_data, input pix_ready);
    modport slave  (input pix_valid, pix_x, pix_y, pix_data, output pix_ready);
endinterface

// File: rtl/framebuffer_write_scheduler_fifo.sv
// Small synchronous FIFO of pending pixel writes; flush empties it in one cycle.
module pixel_write_fifo
    import framebuffer_write_scheduler_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      flush,
    input  logic      push,
    input  logic      pop,
    input  PixelWrite din,
    output PixelWrite dout,
    output logic      full,
    output logic      empty
);
    localparam int PW = $clog2(DEPTH);

    PixelWrite     mem [DEPTH];
    logic [PW:0]   wr_ptr;
    logic [PW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Extra pointer bit distinguishes full from empty.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (PW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr[PW-1:0]] <= din;
    end

endmodule

// File: rtl/framebuffer_write_scheduler.sv
// Owns pixel BRAM port A: background clear sweep, then the raytracer pixel stream,
// with frame-completion flag and render cycle/write counters.
module framebuffer_write_scheduler
    import framebuffer_write_scheduler_pkg::*;
#(
    parameter int FRAME_WIDTH   = 512,
    parameter int FRAME_HEIGHT  = 384,
    parameter int SCREEN_WIDTH  = 512,
    parameter int SCREEN_HEIGHT = 384,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear_start,
    input  logic [COLOR_BITS-1:0]        clear_color,
    framebuffer_write_scheduler_if.slave pix,
    output logic                         bram_we,
    output logic [ADDR_BITS-1:0]         bram_addr,
    output logic [COLOR_BITS-1:0]        bram_din,
    output logic                         clear_busy,
    output logic                         frame_done,
    output logic [63:0]                  cycle_count,
    output logic [31:0]                  write_count
);
    localparam int FB_WORDS = FRAME_WIDTH * FRAME_HEIGHT;
    localparam logic [ADDR_BITS-1:0] LAST_CLEAR = ADDR_BITS'(FB_WORDS - 1);
    localparam logic [ADDR_BITS-1:0] LAST_PIX   =
        ADDR_BITS'(FRAME_WIDTH * (SCREEN_HEIGHT - 1) + SCREEN_WIDTH - 1);

    FbState                state;
    logic [ADDR_BITS-1:0]  clear_addr;
    logic [COLOR_BITS-1:0] color;
    logic                  restart;
    logic                  in_screen;
    logic                  push;
    logic                  pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [ADDR_BITS-1:0]  row_base;
    PixelWrite             fifo_din;
    PixelWrite             fifo_dout;

    // A new frame request mid-sweep is ignored; anywhere else it restarts the frame.
    assign restart   = clear_start && (state != CLEAR);
    assign in_screen = (pix.pix_x < 16'(SCREEN_WIDTH)) && (pix.pix_y < 16'(SCREEN_HEIGHT));
    assign pix.pix_ready = (state != IDLE) && !fifo_full;
    assign push      = pix.pix_valid && pix.pix_ready && in_screen && !restart;
    assign pop       = ((state == STREAM) || (state == DONE)) && !fifo_empty && !restart;

    generate
        if (is_pow2(FRAME_WIDTH)) begin : g_row_shift
            assign row_base = ADDR_BITS'({16'b0, pix.pix_y} << $clog2(FRAME_WIDTH));
        end else begin : g_row_mul
            assign row_base = ADDR_BITS'(32'(pix.pix_y) * 32'(FRAME_WIDTH));
        end
    endgenerate

    assign fifo_din.addr = row_base + ADDR_BITS'(pix.pix_x);
    assign fifo_din.data = pix.pix_data;

    pixel_write_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (restart),
        .push  (push),
        .pop   (pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            clear_addr  <= '0;
            color       <= '0;
            bram_we     <= 1'b0;
            bram_addr   <= '0;
            bram_din    <= '0;
            clear_busy  <= 1'b0;
            frame_done  <= 1'b0;
            cycle_count <= '0;
            write_count <= '0;
        end else begin
            bram_we    <= 1'b0;
            clear_busy <= 1'b0;
            if ((state != IDLE) && !frame_done && (cycle_count != '1))
                cycle_count <= cycle_count + 64'd1;

            if (restart) begin
                // Address 0 goes out on this edge so the sweep starts one cycle after the request.
                state       <= CLEAR;
                color       <= clear_color;
                clear_addr  <= ADDR_BITS'(1);
                bram_we     <= 1'b1;
                clear_busy  <= 1'b1;
                bram_addr   <= '0;
                bram_din    <= clear_color;
                frame_done  <= 1'b0;
                cycle_count <= '0;
                write_count <= '0;
            end else begin
                case (state)
                    CLEAR: begin
                        bram_we    <= 1'b1;
                        clear_busy <= 1'b1;
                        bram_addr  <= clear_addr;
                        bram_din   <= color;
                        clear_addr <= clear_addr + ADDR_BITS'(1);
                        if (clear_addr == LAST_CLEAR) state <= STREAM;
                    end
                    STREAM, DONE: begin
                        if (pop) begin
                            bram_we     <= 1'b1;
                            bram_addr   <= fifo_dout.addr;
                            bram_din    <= fifo_dout.data;
                            write_count <= write_count + 32'd1;
                            if (fifo_dout.addr == LAST_PIX) begin
                                frame_done <= 1'b1;
                                state      <= DONE;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
